// File: rtl/beam_scan_sequencer.sv
// Beam-steering scan sequencer: walks a 7-bit steering index through SETTLE/PING/LISTEN/STEP
// beams, with a serially loaded shadow config. Define ARPAS_BLANKING_EN for receiver ring-down blanking.
module beam_scan_sequencer (
    input  logic       ISYSCLK,
    input  logic       RSTALLD,
    input  logic       PADORUN,
    input  logic       REGDATA,
    input  logic       REGCLKS,
    input  logic       AREGSEL,
    output logic [1:0] PHAMUXS,
    output logic [4:0] TAPSELX,
    output logic       PINGDRV,
    output logic       ECHOGAT,
    output logic       NEXTSIG,
    output logic       FRAMEND,
    output logic       BUSYOUT
);

    localparam logic [6:0] MAX_IDX = 7'd67;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETTLE,
        S_PING,
        S_LISTEN,
        S_STEP
    } state_t;

    state_t      state_q;
    logic [7:0]  cnt_q;
    logic [6:0]  idx_q;
    logic        pingdrv_q;
    logic        echogat_q;
    logic        nextsig_q;
    logic        framend_q;
    logic        busy_q;
`ifdef ARPAS_BLANKING_EN
    logic [3:0]  blank_q;
`endif

    logic [6:0]  lastidx_q;
    logic [3:0]  pinglen_q;
    logic [7:0]  listlen_q;
    logic [18:0] shadow_q;
    logic [18:0] shadow_d;
    logic        pend_q;
    logic        pend_d;
    logic        rclk1_q, rclk2_q, rclk3_q;
    logic        sel1_q, sel2_q, sel3_q;

    logic        shift_edge;
    logic        sel_fall;
    logic        at_wrap;
    logic        apply;
    logic [6:0]  lastidx_d;

    always_comb begin
        shift_edge = rclk2_q & ~rclk3_q;
        sel_fall   = sel3_q & ~sel2_q;
        at_wrap    = (idx_q == lastidx_q);
        // Config may only switch between frames so a frame never mixes timings.
        apply      = pend_q && ((state_q == S_IDLE) || ((state_q == S_STEP) && at_wrap));
        shadow_d   = (shift_edge && sel2_q) ? {shadow_q[17:0], REGDATA} : shadow_q;
        pend_d     = sel_fall | (pend_q & ~apply);
        lastidx_d  = (shadow_q[18:12] > MAX_IDX) ? MAX_IDX : shadow_q[18:12];
    end

    always_ff @(posedge ISYSCLK or negedge RSTALLD) begin
        if (!RSTALLD) begin
            rclk1_q   <= 1'b0;
            rclk2_q   <= 1'b0;
            rclk3_q   <= 1'b0;
            sel1_q    <= 1'b0;
            sel2_q    <= 1'b0;
            sel3_q    <= 1'b0;
            shadow_q  <= '0;
            pend_q    <= 1'b0;
            lastidx_q <= MAX_IDX;
            pinglen_q <= 4'd3;
            listlen_q <= 8'd255;
        end else begin
            rclk1_q  <= REGCLKS;
            rclk2_q  <= rclk1_q;
            rclk3_q  <= rclk2_q;
            sel1_q   <= AREGSEL;
            sel2_q   <= sel1_q;
            sel3_q   <= sel2_q;
            shadow_q <= shadow_d;
            pend_q   <= pend_d;
            if (apply) begin
                lastidx_q <= lastidx_d;
                pinglen_q <= shadow_q[11:8];
                listlen_q <= shadow_q[7:0];
            end
        end
    end

    always_ff @(posedge ISYSCLK or negedge RSTALLD) begin
        if (!RSTALLD) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            idx_q     <= '0;
            pingdrv_q <= 1'b0;
            echogat_q <= 1'b0;
            nextsig_q <= 1'b0;
            framend_q <= 1'b0;
            busy_q    <= 1'b0;
`ifdef ARPAS_BLANKING_EN
            blank_q   <= '0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (apply) begin
                        idx_q <= '0;
                    end
                    if (PADORUN) begin
                        state_q <= S_SETTLE;
                        cnt_q   <= 8'd1;
                        busy_q  <= 1'b1;
                    end
                end
                S_SETTLE: begin
                    if (cnt_q == 8'd0) begin
                        state_q   <= S_PING;
                        cnt_q     <= {4'd0, pinglen_q};
                        pingdrv_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - 8'd1;
                    end
                end
                S_PING: begin
                    if (cnt_q == 8'd0) begin
                        state_q   <= S_LISTEN;
                        cnt_q     <= listlen_q;
                        pingdrv_q <= 1'b0;
`ifdef ARPAS_BLANKING_EN
                        blank_q   <= pinglen_q;
                        echogat_q <= 1'b0;
`else
                        echogat_q <= 1'b1;
`endif
                    end else begin
                        cnt_q <= cnt_q - 8'd1;
                    end
                end
                S_LISTEN: begin
`ifdef ARPAS_BLANKING_EN
                    // Gate opens once the transducer ring-down window has elapsed.
                    if (!echogat_q) begin
                        if (blank_q == 4'd0) begin
                            echogat_q <= 1'b1;
                        end else begin
                            blank_q <= blank_q - 4'd1;
                        end
                    end
`endif
                    if (cnt_q == 8'd0) begin
                        state_q   <= S_STEP;
                        echogat_q <= 1'b0;
                        nextsig_q <= 1'b1;
                        framend_q <= at_wrap;
                    end else begin
                        cnt_q <= cnt_q - 8'd1;
                    end
                end
                S_STEP: begin
                    nextsig_q <= 1'b0;
                    framend_q <= 1'b0;
                    idx_q     <= at_wrap ? 7'd0 : idx_q + 7'd1;
                    if (PADORUN) begin
                        state_q <= S_SETTLE;
                        cnt_q   <= 8'd1;
                    end else begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q   <= S_IDLE;
                    pingdrv_q <= 1'b0;
                    echogat_q <= 1'b0;
                    nextsig_q <= 1'b0;
                    framend_q <= 1'b0;
                    busy_q    <= 1'b0;
                end
            endcase
        end
    end

    assign PHAMUXS = idx_q[1:0];
    assign TAPSELX = idx_q[6:2];
    assign PINGDRV = pingdrv_q;
    assign ECHOGAT = echogat_q;
    assign NEXTSIG = nextsig_q;
    assign FRAMEND = framend_q;
    assign BUSYOUT = busy_q;

endmodule

// File: doc/beam_scan_sequencer.md
BEAM_SCAN_SEQUENCER -- requirements
Module: beam_scan_sequencer

Interface
REQ-001 SHALL: ISYSCLK  in  1  system clock, all state on rising edge.
REQ-002 SHALL: RSTALLD  in  1  reset, asynchronous, active-low.
REQ-003 SHALL: PADORUN  in  1  scan run enable, level.
REQ-004 SHALL: REGDATA  in  1  serial config data, MSB first.
REQ-005 SHALL: REGCLKS  in  1  serial config strobe, asynchronous to ISYSCLK.
REQ-006 SHALL: AREGSEL  in  1  config load window, high = shift enabled.
REQ-007 SHALL: PHAMUXS  out  2  phase-mux rotation select (index[1:0]).
REQ-008 SHALL: TAPSELX  out  5  delay-chain tap select 0..16 (index[6:2]).
REQ-009 SHALL: PINGDRV  out  1  transmit drive, high during PING.
REQ-010 SHALL: ECHOGAT  out  1  receiver gate, high during LISTEN.
REQ-011 SHALL: NEXTSIG  out  1  one-cycle pulse on each completed beam.
REQ-012 SHALL: FRAMEND  out  1  one-cycle pulse, coincident with NEXTSIG, on last beam of frame.
REQ-013 SHALL: BUSYOUT  out  1  high in any state except IDLE.

Function
REQ-014 SHALL: 7-bit steering index IDX, range 0..LASTIDX, LASTIDX <= 67 (17 taps x 4 phases).
REQ-015 SHALL: FSM states IDLE, SETTLE, PING, LISTEN, STEP; IDLE -> SETTLE when PADORUN=1.
REQ-016 SHALL: SETTLE lasts exactly 2 cycles with PHAMUXS/TAPSELX already at new IDX, then PING.
REQ-017 SHALL: PING lasts PINGLEN+1 cycles (PINGLEN 4-bit), then LISTEN.
REQ-018 SHALL: LISTEN lasts LISTLEN+1 cycles (LISTLEN 8-bit), then STEP for 1 cycle.
REQ-019 SHALL: in STEP pulse NEXTSIG; if IDX==LASTIDX pulse FRAMEND and set IDX=0, else IDX+1.
REQ-020 SHALL: in STEP, PADORUN=0 -> IDLE (IDX retained); PADORUN=1 -> SETTLE; PADORUN dropping mid-beam does not abort the beam.
REQ-021 SHALL: REGCLKS synchronised through 2 flops; each synchronised rising edge with AREGSEL=1 shifts REGDATA into 19-bit shadow {LASTIDX[6:0],PINGLEN[3:0],LISTLEN[7:0]}.
REQ-022 SHALL: AREGSEL falling edge (synchronously sampled) sets PEND; shadow copied to active config, and PEND cleared, only in IDLE or in STEP with IDX==LASTIDX.
REQ-023 SHALL: loaded LASTIDX > 67 clamped to 67; applying config in IDLE also resets IDX to 0.
REQ-024 SHALL: counters saturate-free; duration counters reload on every state entry.

Reset
REQ-025 SHALL: RSTALLD low forces immediately: state IDLE, IDX=0, PHAMUXS=0, TAPSELX=0, PINGDRV=0, ECHOGAT=0, NEXTSIG=0, FRAMEND=0, BUSYOUT=0, PEND=0, shadow=0, sync flops=0.
REQ-026 SHALL: active config reset values LASTIDX=67, PINGLEN=3, LISTLEN=255.
REQ-027 SHALL: reset mid-PING deassert PINGDRV asynchronously, without waiting for a clock edge.

Configuration
REQ-028 SHALL: macro ARPAS_BLANKING_EN defined -> ECHOGAT held low for first PINGLEN+1 cycles of LISTEN (ring-down blanking), high for remainder.
REQ-029 SHALL: macro ARPAS_BLANKING_EN undefined -> ECHOGAT high for all LISTEN cycles; no blanking logic built.

Verification
REQ-030 SHALL: reset defaults, PADORUN=1 -> SETTLE 2, PINGDRV high 4 cycles, ECHOGAT 256 cycles, NEXTSIG at STEP; PHAMUXS=0,TAPSELX=0 beam 1, PHAMUXS=1 beam 2.
REQ-031 SHALL: load LASTIDX=5,PINGLEN=0,LISTLEN=2 in IDLE -> beams IDX 0..5, FRAMEND with 6th NEXTSIG, 7th beam IDX=0.
REQ-032 SHALL: load LASTIDX=100 -> clamped, IDX 67 gives PHAMUXS=3,TAPSELX=16, then wrap to 0.
REQ-033 SHALL: config shifted mid-frame (IDX=10 of 67) -> old timing kept until STEP at IDX 67, new timing from next beam.
REQ-034 SHALL: PADORUN dropped during LISTEN -> beam completes, NEXTSIG pulses, IDLE, BUSYOUT=0; RSTALLD low during PING -> PINGDRV=0 same cycle.
REQ-035 SHALL: with ARPAS_BLANKING_EN, PINGLEN=3,LISTLEN=9 -> ECHOGAT low 4 then high 6 LISTEN cycles; without it high 10.
